// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device over the open-drain PS2_CLK/PS2_DAT
// lines. The block only ever pulls lines low; the enclosing level builds the
// tri-states from the *_oe outputs.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   start       single-cycle send request, only honoured while idle
//   tx_byte     byte to send, captured when start is accepted
//   ps2_clk_in  raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in  raw PS2_DAT pin level (asynchronous)
//   ps2_clk_oe  1 = pull PS2_CLK low
//   ps2_dat_oe  1 = pull PS2_DAT low
//   busy        transfer in progress
//   done        one-cycle pulse: byte sent and acknowledged
//   error       one-cycle pulse: timeout or missing acknowledge

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t INH_LAST = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t REQ_LAST = cnt_t'(REQ_CYCLES - 1);
  localparam cnt_t TO_LAST  = cnt_t'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACKWAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [8:0] shreg_q, shreg_d;
  logic [3:0] edge_cnt_q, edge_cnt_d;
  logic       dat_bit_q, dat_bit_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  logic       clk_fall;
  logic [3:0] edge_cnt_inc;

  // Two-flop synchronizers. Idle bus level is high, so reset to 1 to avoid
  // a spurious falling edge right after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign clk_fall     = clk_prev_q & ~clk_s2_q;
  assign edge_cnt_inc = edge_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      edge_cnt_q <= '0;
      dat_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      edge_cnt_q <= edge_cnt_d;
      dat_bit_q  <= dat_bit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    edge_cnt_d = edge_cnt_q;
    dat_bit_d  = dat_bit_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_INHIBIT;
          cnt_d      = '0;
          shreg_d    = {~^tx_byte, tx_byte};
          edge_cnt_d = '0;
          dat_bit_d  = 1'b0;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      ST_REQ: begin
        if (cnt_q == REQ_LAST) begin
          // Counter restarts as the timeout; data stays low as the start
          // bit until the device's first falling edge.
          state_d   = ST_SEND;
          cnt_d     = '0;
          dat_bit_d = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      ST_SEND: begin
        cnt_d = cnt_q + cnt_t'(1);
        // Timeout is checked first so it beats a coincident edge 11.
        if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else if (clk_fall) begin
          edge_cnt_d = edge_cnt_inc;
          if (edge_cnt_inc <= 4'd9) begin
            dat_bit_d = ~shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end else if (edge_cnt_inc == 4'd10) begin
            dat_bit_d = 1'b0;
          end else begin
            state_d = dat_s2_q ? ST_ERR : ST_ACKWAIT;
          end
        end
      end

      ST_ACKWAIT: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else if (clk_s2_q && dat_s2_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset releases both
  // lines immediately.
  assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  assign ps2_dat_oe = (state_q == ST_REQ) || ((state_q == ST_SEND) && dat_bit_q);
  assign busy       = (state_q == ST_INHIBIT) || (state_q == ST_REQ) ||
                      (state_q == ST_SEND) || (state_q == ST_ACKWAIT);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int REQ = 4;
  localparam int TO  = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_byte;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int done_seen = 0;
  int err_seen  = 0;
  int both_seen = 0;
  logic err_clk_oe = 1'b0;
  logic err_dat_oe = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tx_byte   (tx_byte),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen <= done_seen + 1;
    if (error) begin
      err_seen   <= err_seen + 1;
      err_clk_oe <= ps2_clk_oe;
      err_dat_oe <= ps2_dat_oe;
    end
    if (done && error) both_seen <= both_seen + 1;
  end

  // Reference frame as the device sees it: start 0, data LSB first,
  // odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    start   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Device: waits for clock release after a request, then clocks 11 bits at
  // a 20-cycle period, sampling the data line in each high phase. With ack
  // set it pulls data low before the 11th falling edge. inj_kind 1 pulses
  // start with 0x55 at edge inj_edge; inj_kind 2 asserts reset there.
  task automatic dev_frame(input bit ack, input int inj_edge, input int inj_kind,
                           output logic [10:0] bits, output bit aborted);
    int wait_n;
    bits    = '0;
    aborted = 1'b0;
    wait_n  = 0;
    while (!(busy && !ps2_clk_oe) && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("dev_request_seen", 32'(wait_n < 100), 32'd1);
    if (wait_n >= 100) return;
    for (int k = 0; k < 11; k++) begin
      repeat (5) @(negedge clk);
      bits[k] = ps2_dat_in;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      if (inj_edge == k + 1 && inj_kind == 1) begin
        start   = 1'b1;
        tx_byte = 8'h55;
        @(negedge clk);
        start   = 1'b0;
        repeat (9) @(negedge clk);
      end else if (inj_edge == k + 1 && inj_kind == 2) begin
        reset = 1'b0;
        #1;
        check("rst_async_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_async_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_async_busy",   32'(busy),       32'd0);
        check("rst_async_done",   32'(done),       32'd0);
        check("rst_async_error",  32'(error),      32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        aborted     = 1'b1;
        return;
      end else begin
        repeat (10) @(negedge clk);
      end
      dev_clk_low = 1'b0;
    end
    repeat (5) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  // Called on the cycle the device lets go of data after an ACK.
  task automatic expect_done(input string tag, input int done_before);
    int lat;
    lat = 0;
    while (!done && !error && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"},         32'(done),  32'd1);
    check({tag, "_done_latency"}, 32'(lat),   32'd3);
    check({tag, "_busy_at_done"}, 32'(busy),  32'd0);
    check({tag, "_no_error"},     32'(error), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"},   32'(done),  32'd0);
    check({tag, "_done_count"},   32'(done_seen - done_before), 32'd1);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  b;
    bit          ab;
    int          d0;
    int          e0;
    int          n;

    reset   = 1'b0;
    start   = 1'b0;
    tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("reset_busy",   32'(busy),       32'd0);
    check("reset_done",   32'(done),       32'd0);
    check("reset_error",  32'(error),      32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 0xED with exact request timing
    d0 = done_seen; e0 = err_seen;
    send_start(8'hED);
    check("ed_busy_rise",   32'(busy),       32'd1);
    check("ed_clk_oe_rise", 32'(ps2_clk_oe), 32'd1);
    check("ed_dat_oe_low",  32'(ps2_dat_oe), 32'd0);
    repeat (INH - 1) @(negedge clk);
    check("ed_dat_oe_before", 32'(ps2_dat_oe), 32'd0);
    @(negedge clk);
    check("ed_dat_oe_at_inh", 32'(ps2_dat_oe), 32'd1);
    check("ed_clk_oe_in_req", 32'(ps2_clk_oe), 32'd1);
    repeat (REQ - 1) @(negedge clk);
    check("ed_clk_oe_before_rel", 32'(ps2_clk_oe), 32'd1);
    @(negedge clk);
    check("ed_clk_oe_released", 32'(ps2_clk_oe), 32'd0);
    check("ed_start_bit_held",  32'(ps2_dat_oe), 32'd1);
    dev_frame(1'b1, 0, 0, bits, ab);
    check("ed_frame_bits", 32'(bits), 32'(frame_model(8'hED)));
    expect_done("ed", d0);
    check("ed_no_error_pulse", 32'(err_seen - e0), 32'd0);

    // 0xF4
    d0 = done_seen;
    send_start(8'hF4);
    dev_frame(1'b1, 0, 0, bits, ab);
    check("f4_frame_bits", 32'(bits), 32'(frame_model(8'hF4)));
    expect_done("f4", d0);

    // 0x00 without ACK
    d0 = done_seen; e0 = err_seen;
    send_start(8'h00);
    dev_frame(1'b0, 0, 0, bits, ab);
    repeat (5) @(negedge clk);
    check("nack_frame_bits",  32'(bits), 32'(frame_model(8'h00)));
    check("nack_error_count", 32'(err_seen - e0),  32'd1);
    check("nack_done_count",  32'(done_seen - d0), 32'd0);
    check("nack_err_clk_oe",  32'(err_clk_oe), 32'd0);
    check("nack_err_dat_oe",  32'(err_dat_oe), 32'd0);
    check("nack_busy_after",  32'(busy),       32'd0);

    // Device never clocks
    e0 = err_seen;
    send_start(8'hA5);
    n = 0;
    while (ps2_clk_oe && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_clk_released", 32'(ps2_clk_oe), 32'd0);
    n = 0;
    while (!error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("to_latency",    32'(n),          32'(TO));
    check("to_error",      32'(error),      32'd1);
    check("to_clk_oe",     32'(ps2_clk_oe), 32'd0);
    check("to_dat_oe",     32'(ps2_dat_oe), 32'd0);
    @(negedge clk);
    check("to_error_count", 32'(err_seen - e0), 32'd1);

    // Second start mid-frame is ignored
    d0 = done_seen;
    send_start(8'hED);
    dev_frame(1'b1, 4, 1, bits, ab);
    check("restart_frame_bits", 32'(bits), 32'(frame_model(8'hED)));
    expect_done("restart", d0);
    repeat (INH + REQ + 5) @(negedge clk);
    check("restart_stays_idle", 32'(busy), 32'd0);

    // Reset mid-frame, then a clean 0xFF
    send_start(8'hED);
    dev_frame(1'b1, 6, 2, bits, ab);
    check("rst_aborted", 32'(ab), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_held_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_seen;
    send_start(8'hFF);
    dev_frame(1'b1, 0, 0, bits, ab);
    check("ff_frame_bits", 32'(bits), 32'(frame_model(8'hFF)));
    expect_done("ff", d0);

    // Random bytes
    for (int r = 0; r < 4; r++) begin
      b  = 8'($urandom_range(0, 255));
      d0 = done_seen;
      send_start(b);
      dev_frame(1'b1, 0, 0, bits, ab);
      check("rand_frame_bits", 32'(bits), 32'(frame_model(b)));
      expect_done("rand", d0);
    end

    check("done_error_exclusive", 32'(both_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
